// File: rtl/jts16_pkg.sv
// rtl/jts16_pkg.sv - shared constants and types for the System 16 download packer
package jts16_pkg;

    localparam logic [1:0] BA_CPU  = 2'd0;
    localparam logic [1:0] BA_SND  = 2'd1;
    localparam logic [1:0] BA_PCM  = 2'd1;
    localparam logic [1:0] BA_OBJ  = 2'd2;
    localparam logic [1:0] BA_TILE = 2'd3;

    localparam logic [24:0] DEF_HEADER     = 25'h10;
    localparam logic [24:0] DEF_SND_START  = 25'h4_0010;
    localparam logic [24:0] DEF_PCM_START  = 25'h4_8010;
    localparam logic [24:0] DEF_TILE_START = 25'h5_0010;
    localparam logic [24:0] DEF_OBJ_START  = 25'h8_0010;
    localparam logic [24:0] DEF_ROM_END    = 25'h10_0010;

    localparam logic [21:0] DEF_CPU_OFFSET  = 22'h10_0000;
    localparam logic [21:0] DEF_SND_OFFSET  = 22'h10_0000;
    localparam logic [21:0] DEF_PCM_OFFSET  = 22'h0;
    localparam logic [21:0] DEF_TILE_OFFSET = 22'h0;
    localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h0;

    typedef enum logic [2:0] {
        REG_HDR, REG_CPU, REG_SND, REG_PCM, REG_TILE, REG_OBJ, REG_NONE
    } region_t;

    typedef enum logic {
        ST_IDLE, ST_WAIT
    } wr_state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        logic [1:0]  ba;
    } prog_entry_t;

    localparam int ENTRY_W = $bits(prog_entry_t);

endpackage

// File: rtl/jts16_prog_fifo.sv
// rtl/jts16_prog_fifo.sv - two-entry registered queue of pending SDRAM writes
module jts16_prog_fifo
    import jts16_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/jts16_prog_packer.sv
// rtl/jts16_prog_packer.sv - maps ioctl download bytes to masked SDRAM writes and header config
module jts16_prog_packer
    import jts16_pkg::*;
#(
    parameter logic [24:0] HEADER      = DEF_HEADER,
    parameter logic [24:0] SND_START   = DEF_SND_START,
    parameter logic [24:0] PCM_START   = DEF_PCM_START,
    parameter logic [24:0] TILE_START  = DEF_TILE_START,
    parameter logic [24:0] OBJ_START   = DEF_OBJ_START,
    parameter logic [24:0] ROM_END     = DEF_ROM_END,
    parameter logic [21:0] CPU_OFFSET  = DEF_CPU_OFFSET,
    parameter logic [21:0] SND_OFFSET  = DEF_SND_OFFSET,
    parameter logic [21:0] PCM_OFFSET  = DEF_PCM_OFFSET,
    parameter logic [21:0] TILE_OFFSET = DEF_TILE_OFFSET,
    parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        cfg_we,
    output logic [3:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        dwnld_busy,
    output logic        ovf
);

    region_t     region;
    logic [24:0] rstart;
    logic [21:0] roff;
    logic [1:0]  rba;
    logic [24:0] rel;
    logic        accept;
    logic        rom_byte;
    logic        push;
    logic        pop;
    logic        load;
    logic        fifo_full;
    logic        fifo_empty;
    prog_entry_t push_entry;
    prog_entry_t head;
    logic [ENTRY_W-1:0] fifo_dout;
    wr_state_t   state_q;
    wr_state_t   state_d;

    // Highest region start not above the address wins
    always_comb begin
        region = REG_NONE;
        rstart = HEADER;
        roff   = CPU_OFFSET;
        rba    = BA_CPU;
        if (ioctl_addr < HEADER) begin
            region = REG_HDR;
        end else if (ioctl_addr < SND_START) begin
            region = REG_CPU;
        end else if (ioctl_addr < PCM_START) begin
            region = REG_SND;  rstart = SND_START;  roff = SND_OFFSET;  rba = BA_SND;
        end else if (ioctl_addr < TILE_START) begin
            region = REG_PCM;  rstart = PCM_START;  roff = PCM_OFFSET;  rba = BA_PCM;
        end else if (ioctl_addr < OBJ_START) begin
            region = REG_TILE; rstart = TILE_START; roff = TILE_OFFSET; rba = BA_TILE;
        end else if (ioctl_addr < ROM_END) begin
            region = REG_OBJ;  rstart = OBJ_START;  roff = OBJ_OFFSET;  rba = BA_OBJ;
        end
    end

    assign rel        = ioctl_addr - rstart;
    assign accept     = ioctl_wr & downloading;
    assign rom_byte   = accept & (region != REG_HDR) & (region != REG_NONE);
    assign push       = rom_byte & ~fifo_full;
    assign push_entry = '{addr: roff + 22'(rel >> 1),
                          data: ioctl_data,
                          mask: rel[0] ? 2'b01 : 2'b10,
                          ba:   rba};
    assign head       = prog_entry_t'(fifo_dout);

    jts16_prog_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_we   <= 1'b0;
            cfg_addr <= 4'd0;
            cfg_data <= 8'd0;
            ovf      <= 1'b0;
        end else begin
            cfg_we <= accept & (region == REG_HDR);
            if (accept & (region == REG_HDR)) begin
                cfg_addr <= ioctl_addr[3:0];
                cfg_data <= ioctl_data;
            end
            if (rom_byte & fifo_full) begin
                ovf <= 1'b1;
            end
        end
    end

    // An entry leaves the queue when it is loaded into the output registers
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (prog_rdy) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= 22'd0;
            prog_data <= 16'd0;
            prog_mask <= 2'd0;
            prog_ba   <= 2'd0;
        end else begin
            state_q <= state_d;
            prog_we <= (state_d == ST_WAIT);
            if (load) begin
                prog_addr <= head.addr;
                prog_data <= {head.data, head.data};
                prog_mask <= head.mask;
                prog_ba   <= head.ba;
            end
        end
    end

    assign dwnld_busy = downloading | ~fifo_empty | (state_q == ST_WAIT);

endmodule
